// File: rtl/as_pc_unit_pkg.sv
// rtl/as_pc_unit_pkg.sv - shared types and constants for the program-counter unit
// Purpose: FSM state encoding, default instruction-address width and sequential PC step.
// Ports: none (package).
package as_pc_unit_pkg;

    localparam int iaddr_width = 64;
    localparam int PC_STEP     = 4;

    typedef enum logic [1:0] {
        PC_BOOT,
        PC_RUN,
        PC_PEND
    } pc_state_t;

endpackage

// File: rtl/as_pc_sel.sv
// rtl/as_pc_sel.sv - combinational next-PC priority mux with redirect alignment check
// Purpose: chooses the next PC and next pending-redirect contents from trap, redirect,
//          pending and sequential sources; flags rejected misaligned redirect targets.
// Ports:
//   active_i         unit is out of BOOT (RUN or PEND)
//   stall_i          hold PC, latch redirects
//   fetch_gnt_i      imem accepted the current fetch
//   redirect_v_i/pc  branch/jump redirect
//   trap_v_i/pc      trap entry (target trusted, never alignment-checked)
//   pc_i             current PC
//   pending_v_i/pc   latched redirect from an earlier stall
//   fetch_req_o      fetch request valid
//   pc_nxt_o         PC for the next cycle
//   pending_v_nxt_o  pending valid for the next cycle
//   pending_pc_nxt_o pending target for the next cycle
//   misalign_o       current redirect is being rejected as misaligned
module as_pc_sel
    import as_pc_unit_pkg::*;
#(
    parameter int PC_W    = iaddr_width,
    parameter int ALIGN_C = 0
) (
    input  logic            active_i,
    input  logic            stall_i,
    input  logic            fetch_gnt_i,
    input  logic            redirect_v_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    input  logic            trap_v_i,
    input  logic [PC_W-1:0] trap_pc_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            pending_v_i,
    input  logic [PC_W-1:0] pending_pc_i,
    output logic            fetch_req_o,
    output logic [PC_W-1:0] pc_nxt_o,
    output logic            pending_v_nxt_o,
    output logic [PC_W-1:0] pending_pc_nxt_o,
    output logic            misalign_o
);

    logic misaligned;
    logic redirect_ok;

    assign misaligned  = (ALIGN_C != 0) ? redirect_pc_i[0] : (redirect_pc_i[1:0] != 2'b00);
    // A rejected target behaves as if no redirect arrived at all.
    assign redirect_ok = redirect_v_i && !misaligned;
    assign fetch_req_o = active_i && !stall_i;

    always_comb begin
        pc_nxt_o         = pc_i;
        pending_v_nxt_o  = pending_v_i;
        pending_pc_nxt_o = pending_pc_i;
        misalign_o       = 1'b0;
        if (active_i) begin
            if (trap_v_i) begin
                // Trap beats everything, even a stall, and kills any latched redirect.
                pc_nxt_o        = trap_pc_i;
                pending_v_nxt_o = 1'b0;
            end else begin
                misalign_o = redirect_v_i && misaligned;
                if (stall_i) begin
                    if (redirect_ok) begin
                        pending_pc_nxt_o = redirect_pc_i;
                        pending_v_nxt_o  = 1'b1;
                    end
                end else if (redirect_ok) begin
                    // A fresh redirect is younger than the pending one, so it wins.
                    pc_nxt_o        = redirect_pc_i;
                    pending_v_nxt_o = 1'b0;
                end else if (pending_v_i) begin
                    pc_nxt_o        = pending_pc_i;
                    pending_v_nxt_o = 1'b0;
                end else if (fetch_gnt_i) begin
                    pc_nxt_o = pc_i + PC_W'(PC_STEP);
                end
            end
        end
    end

endmodule

// File: rtl/as_pc_unit.sv
// rtl/as_pc_unit.sv - fetch program-counter unit with boot delay and stall-safe redirects
// Purpose: holds the fetch PC, issues fetch requests, and keeps redirects that arrive
//          during a stall until the stall releases.
// Ports:
//   clk_i, rst_i (async, active-high)
//   stall_i                       decode back-pressure
//   redirect_v_i, redirect_pc_i   branch/jump redirect
//   trap_v_i, trap_pc_i           trap / mret entry
//   fetch_req_o, fetch_pc_o       fetch request and address (registered PC)
//   fetch_gnt_i                   imem accept
//   misalign_o, misalign_addr_o   one-cycle reject pulse and last rejected target
//   booting_o                     high in BOOT
module as_pc_unit
    import as_pc_unit_pkg::*;
#(
    parameter int              PC_W       = iaddr_width,
    parameter logic [PC_W-1:0] RESET_VEC  = '0,
    parameter int              BOOT_DELAY = 2,
    parameter int              ALIGN_C    = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            redirect_v_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    input  logic            trap_v_i,
    input  logic [PC_W-1:0] trap_pc_i,
    output logic            fetch_req_o,
    output logic [PC_W-1:0] fetch_pc_o,
    input  logic            fetch_gnt_i,
    output logic            misalign_o,
    output logic [PC_W-1:0] misalign_addr_o,
    output logic            booting_o
);

    localparam logic [3:0] BOOT_CNT = 4'(BOOT_DELAY);

    pc_state_t       state_q, state_d;
    logic [3:0]      boot_cnt_q, boot_cnt_d;
    logic [PC_W-1:0] pc_q, pc_nxt;
    logic [PC_W-1:0] pending_pc_q, pending_pc_nxt;
    logic            pending_v_nxt;
    logic            misalign_nxt;
    logic            misalign_q;
    logic [PC_W-1:0] misalign_addr_q;

    as_pc_sel #(
        .PC_W    (PC_W),
        .ALIGN_C (ALIGN_C)
    ) u_sel (
        .active_i         (state_q != PC_BOOT),
        .stall_i          (stall_i),
        .fetch_gnt_i      (fetch_gnt_i),
        .redirect_v_i     (redirect_v_i),
        .redirect_pc_i    (redirect_pc_i),
        .trap_v_i         (trap_v_i),
        .trap_pc_i        (trap_pc_i),
        .pc_i             (pc_q),
        .pending_v_i      (state_q == PC_PEND),
        .pending_pc_i     (pending_pc_q),
        .fetch_req_o      (fetch_req_o),
        .pc_nxt_o         (pc_nxt),
        .pending_v_nxt_o  (pending_v_nxt),
        .pending_pc_nxt_o (pending_pc_nxt),
        .misalign_o       (misalign_nxt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= PC_BOOT;
            boot_cnt_q      <= '0;
            pc_q            <= RESET_VEC;
            pending_pc_q    <= '0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            boot_cnt_q   <= boot_cnt_d;
            pc_q         <= pc_nxt;
            pending_pc_q <= pending_pc_nxt;
            misalign_q   <= misalign_nxt;
            if (misalign_nxt) begin
                misalign_addr_q <= redirect_pc_i;
            end
        end
    end

    // PEND is exactly "a latched redirect is waiting", so the pending-valid flag is the state.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        case (state_q)
            PC_BOOT: begin
                if (boot_cnt_q == BOOT_CNT) begin
                    state_d = PC_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + 4'd1;
                end
            end
            PC_RUN, PC_PEND: begin
                state_d = pending_v_nxt ? PC_PEND : PC_RUN;
            end
            default: state_d = PC_BOOT;
        endcase
    end

    assign fetch_pc_o      = pc_q;
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = misalign_addr_q;
    assign booting_o       = (state_q == PC_BOOT);

endmodule

// File: tb/tb_as_pc_unit.sv
// tb/tb_as_pc_unit.sv - directed self-checking bench for as_pc_unit
module tb_as_pc_unit;

    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall, rv, tv, gnt;
    logic [PC_W-1:0] rpc, tpc;

    logic            req0, mis0, boot0, req1, mis1, boot1;
    logic [PC_W-1:0] pc0, maddr0, pc1, maddr1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    as_pc_unit #(.PC_W(PC_W), .RESET_VEC('0), .BOOT_DELAY(2), .ALIGN_C(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_v_i(rv), .redirect_pc_i(rpc),
        .trap_v_i(tv), .trap_pc_i(tpc), .fetch_req_o(req0), .fetch_pc_o(pc0),
        .fetch_gnt_i(gnt), .misalign_o(mis0), .misalign_addr_o(maddr0), .booting_o(boot0)
    );

    as_pc_unit #(.PC_W(PC_W), .RESET_VEC('0), .BOOT_DELAY(2), .ALIGN_C(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_v_i(rv), .redirect_pc_i(rpc),
        .trap_v_i(tv), .trap_pc_i(tpc), .fetch_req_o(req1), .fetch_pc_o(pc1),
        .fetch_gnt_i(gnt), .misalign_o(mis1), .misalign_addr_o(maddr1), .booting_o(boot1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 0; rv = 0; tv = 0; gnt = 1; rpc = '0; tpc = '0;
        step(); step();
        total_cnt++; if (req0 !== 1'b0) $display("FAIL rst_req got %0b exp 0", req0); else pass_cnt++;
        total_cnt++; if (pc0 !== 32'h0) $display("FAIL rst_pc got %h exp 0", pc0); else pass_cnt++;
        total_cnt++; if (boot0 !== 1'b1) $display("FAIL rst_boot got %0b exp 1", boot0); else pass_cnt++;
        total_cnt++; if (mis0 !== 1'b0 || maddr0 !== 32'h0) $display("FAIL rst_mis got %0b/%h exp 0/0", mis0, maddr0); else pass_cnt++;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++; if (req0 !== 1'b0 || boot0 !== 1'b1) $display("FAIL boot_cyc%0d req/boot got %0b/%0b exp 0/1", i, req0, boot0); else pass_cnt++;
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++; if (req0 !== 1'b1 || pc0 !== 32'(i * 4)) $display("FAIL seq%0d req/pc got %0b/%h exp 1/%h", i, req0, pc0, 32'(i * 4)); else pass_cnt++;
        end
        total_cnt++; if (boot0 !== 1'b0) $display("FAIL run_boot got %0b exp 0", boot0); else pass_cnt++;
    endtask

    task automatic test_stall_redirect();
        rv = 1; rpc = 32'h100;
        step();
        total_cnt++; if (pc0 !== 32'h100) $display("FAIL redir_pc got %h exp 100", pc0); else pass_cnt++;
        stall = 1; rpc = 32'h400;
        #1;
        total_cnt++; if (req0 !== 1'b0) $display("FAIL stall_req got %0b exp 0", req0); else pass_cnt++;
        step();
        rv = 0;
        step(); step();
        total_cnt++; if (pc0 !== 32'h100) $display("FAIL stall_hold got %h exp 100", pc0); else pass_cnt++;
        stall = 0;
        #1;
        total_cnt++; if (req0 !== 1'b1) $display("FAIL unstall_req got %0b exp 1", req0); else pass_cnt++;
        step();
        total_cnt++; if (pc0 !== 32'h400) $display("FAIL pend_load got %h exp 400", pc0); else pass_cnt++;
        step();
        total_cnt++; if (pc0 !== 32'h404) $display("FAIL pend_seq got %h exp 404", pc0); else pass_cnt++;
    endtask

    task automatic test_trap_pending();
        stall = 1; rv = 1; rpc = 32'h400;
        step();
        rv = 0; tv = 1; tpc = 32'h80;
        step();
        total_cnt++; if (pc0 !== 32'h80) $display("FAIL trap_stall got %h exp 80", pc0); else pass_cnt++;
        tv = 0;
        step();
        stall = 0;
        #1;
        total_cnt++; if (pc0 !== 32'h80 || req0 !== 1'b1) $display("FAIL trap_fetch pc/req got %h/%0b exp 80/1", pc0, req0); else pass_cnt++;
        step();
        total_cnt++; if (pc0 !== 32'h84) $display("FAIL trap_discard got %h exp 84", pc0); else pass_cnt++;
    endtask

    task automatic test_misalign();
        rv = 1; rpc = 32'h202;
        step();
        total_cnt++; if (pc0 !== 32'h88) $display("FAIL mis_a0_pc got %h exp 88", pc0); else pass_cnt++;
        total_cnt++; if (mis0 !== 1'b1 || maddr0 !== 32'h202) $display("FAIL mis_a0_pulse got %0b/%h exp 1/202", mis0, maddr0); else pass_cnt++;
        total_cnt++; if (pc1 !== 32'h202 || mis1 !== 1'b0) $display("FAIL mis_a1 pc/mis got %h/%0b exp 202/0", pc1, mis1); else pass_cnt++;
        rv = 0;
        step();
        total_cnt++; if (mis0 !== 1'b0 || maddr0 !== 32'h202) $display("FAIL mis_one_cycle got %0b/%h exp 0/202", mis0, maddr0); else pass_cnt++;
        total_cnt++; if (pc0 !== 32'h8C || pc1 !== 32'h206) $display("FAIL mis_after pc0/pc1 got %h/%h exp 8c/206", pc0, pc1); else pass_cnt++;
        tv = 1; tpc = 32'h40; rv = 1; rpc = 32'h303;
        step();
        total_cnt++; if (pc0 !== 32'h40 || pc1 !== 32'h40) $display("FAIL trap_vs_redir pc0/pc1 got %h/%h exp 40/40", pc0, pc1); else pass_cnt++;
        total_cnt++; if (mis0 !== 1'b0 || mis1 !== 1'b0) $display("FAIL trap_no_mis got %0b/%0b exp 0/0", mis0, mis1); else pass_cnt++;
        tv = 0; stall = 1; rpc = 32'h301;
        step();
        total_cnt++; if (mis0 !== 1'b1 || maddr0 !== 32'h301) $display("FAIL mis_stall got %0b/%h exp 1/301", mis0, maddr0); else pass_cnt++;
        rv = 0; stall = 0;
        step();
        total_cnt++; if (pc0 !== 32'h44) $display("FAIL mis_not_pending got %h exp 44", pc0); else pass_cnt++;
    endtask

    task automatic test_wrap_hold();
        rv = 1; rpc = 32'hFFFF_FFFC;
        step();
        total_cnt++; if (pc0 !== 32'hFFFF_FFFC) $display("FAIL wrap_load got %h exp fffffffc", pc0); else pass_cnt++;
        rv = 0;
        step();
        total_cnt++; if (pc0 !== 32'h0) $display("FAIL wrap got %h exp 0", pc0); else pass_cnt++;
        gnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            total_cnt++; if (pc0 !== 32'h0 || req0 !== 1'b1) $display("FAIL nognt%0d pc/req got %h/%0b exp 0/1", i, pc0, req0); else pass_cnt++;
        end
        gnt = 1;
    endtask

    task automatic test_reset_mid_pend();
        step();
        stall = 1; rv = 1; rpc = 32'h500;
        step();
        rv = 0;
        #2;
        rst = 1;
        #1;
        total_cnt++; if (pc0 !== 32'h0 || boot0 !== 1'b1 || req0 !== 1'b0) $display("FAIL async_rst pc/boot/req got %h/%0b/%0b exp 0/1/0", pc0, boot0, req0); else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 0; stall = 0;
        step(); step();
        total_cnt++; if (req0 !== 1'b0) $display("FAIL reboot_req got %0b exp 0", req0); else pass_cnt++;
        step();
        total_cnt++; if (req0 !== 1'b1 || pc0 !== 32'h0) $display("FAIL reboot_pc got %0b/%h exp 1/0", req0, pc0); else pass_cnt++;
        step();
        total_cnt++; if (pc0 !== 32'h4) $display("FAIL pend_lost got %h exp 4", pc0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stall_redirect();
        test_trap_pending();
        test_misalign();
        test_wrap_hold();
        test_reset_mid_pend();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
